// File: rtl/sr_latch_ctrl_pkg.sv
// Shared types and constants for the SR-latch bank sequencer.
// Holds the FSM state encoding, the op encoding and the default parameter values.
package sr_latch_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_PULSE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_CHECK = 3'd4
   } state_t;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_RST = 1'b0;

   localparam int DEF_NREQ      = 4;
   localparam int DEF_NFLAG     = 8;
   localparam int DEF_FW        = 3;
   localparam int DEF_PULSE_CYC = 2;

endpackage

// File: rtl/sr_latch_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// after ptr, wrapping, and returns it both one-hot and encoded.
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   winner,
   output logic            valid
);

   logic [PW:0]   sum;
   logic [PW-1:0] cand;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      grant  = '0;
      winner = '0;
      valid  = 1'b0;
      sum    = '0;
      cand   = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum = {1'b0, ptr} + (PW+1)'(i);
         if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
         cand = sum[PW-1:0];
         if (!valid && req[cand]) begin
            valid  = 1'b1;
            winner = cand;
         end
      end
      grant[winner] = valid;
   end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequencer/arbiter for a bank of gated SR latches: grants requesters round-robin,
// drives setup/pulse/hold on the shared enable and S/R lines, then reads back and acks.
module sr_latch_ctrl
   import sr_latch_ctrl_pkg::*;
#(
   parameter int NREQ      = DEF_NREQ,
   parameter int NFLAG     = DEF_NFLAG,
   parameter int FW        = DEF_FW,
   parameter int PULSE_CYC = DEF_PULSE_CYC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   op,
   input  logic [NREQ*FW-1:0] idx,
   output logic [NREQ-1:0]   ack,
   output logic              err,
   output logic              busy,
   output logic              lat_e,
   output logic [NFLAG-1:0]  lat_s,
   output logic [NFLAG-1:0]  lat_r,
   input  logic [NFLAG-1:0]  q_fb
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

   state_t            state_q, state_d;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              op_q, op_d;
   logic              bad_q, bad_d;
   logic [FW-1:0]     idx_q, idx_d;

   logic [NREQ-1:0]   grant;
   logic [PW-1:0]     win_idx;
   logic              gnt_valid;
   logic [FW-1:0]     idx_sel;
   logic              op_sel;
   logic              q_sel;

   logic [NREQ-1:0]   ack_d;
   logic              err_d, busy_d, lat_e_d;
   logic [NFLAG-1:0]  lat_s_d, lat_r_d;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req    (req),
      .ptr    (rr_ptr_q),
      .grant  (grant),
      .winner (win_idx),
      .valid  (gnt_valid)
   );

   always_comb begin
      idx_sel = '0;
      for (int k = 0; k < NREQ; k++)
         if (PW'(k) == win_idx) idx_sel = idx[k*FW +: FW];
   end

   assign op_sel = op[win_idx];

   always_comb begin
      q_sel = 1'b0;
      for (int f = 0; f < NFLAG; f++)
         if (FW'(f) == idx_d) q_sel = q_fb[f];
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gnt_d    = gnt_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      bad_d    = bad_q;
      idx_d    = idx_q;
      unique case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               gnt_d    = grant;
               op_d     = op_sel;
               idx_d    = idx_sel;
               rr_ptr_d = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
               bad_d    = (int'(idx_sel) >= NFLAG);
               state_d  = (int'(idx_sel) >= NFLAG) ? ST_CHECK : ST_SETUP;
            end
         end
         ST_SETUP: begin
            cnt_d   = '0;
            state_d = ST_PULSE;
         end
         ST_PULSE: begin
            if (cnt_q == CW'(PULSE_CYC - 1)) state_d = ST_HOLD;
            else                             cnt_d   = cnt_q + 1'b1;
         end
         ST_HOLD:  state_d = ST_CHECK;
         ST_CHECK: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they come straight off flops.
   always_comb begin
      lat_e_d = (state_d == ST_PULSE);
      lat_s_d = '0;
      lat_r_d = '0;
      if (state_d inside {ST_SETUP, ST_PULSE, ST_HOLD}) begin
         for (int f = 0; f < NFLAG; f++) begin
            if (FW'(f) == idx_d) begin
               lat_s_d[f] = (op_d == OP_SET);
               lat_r_d[f] = (op_d == OP_RST);
            end
         end
      end
      ack_d  = (state_d == ST_CHECK) ? gnt_d : '0;
      err_d  = (state_d == ST_CHECK) && (bad_d || (q_sel != op_d));
      busy_d = (state_d != ST_IDLE);
   end

   // NOTE: non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         gnt_q    <= '0;
         cnt_q    <= '0;
         op_q     <= 1'b0;
         bad_q    <= 1'b0;
         idx_q    <= '0;
         ack      <= '0;
         err      <= 1'b0;
         busy     <= 1'b0;
         lat_e    <= 1'b0;
         lat_s    <= '0;
         lat_r    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_q    <= gnt_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         bad_q    <= bad_d;
         idx_q    <= idx_d;
         ack      <= ack_d;
         err      <= err_d;
         busy     <= busy_d;
         lat_e    <= lat_e_d;
         lat_s    <= lat_s_d;
         lat_r    <= lat_r_d;
      end
   end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Self-checking bench for sr_latch_ctrl: behavioural latch bank, per-requester
// scoreboard of expected err bits, directed scenarios and a random soak.
module tb_sr_latch_ctrl;
   import sr_latch_ctrl_pkg::*;

   localparam int NREQ      = 4;
   localparam int NFLAG     = 6;
   localparam int FW        = 3;
   localparam int PULSE_CYC = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   op;
   logic [NREQ*FW-1:0] idx_v;
   logic [NREQ-1:0]   ack;
   logic              err;
   logic              busy;
   logic              lat_e;
   logic [NFLAG-1:0]  lat_s;
   logic [NFLAG-1:0]  lat_r;
   logic [NFLAG-1:0]  q_fb;
   logic [NFLAG-1:0]  q_lat = '0;
   logic [NFLAG-1:0]  force_low = '0;

   int checks = 0;
   int errors = 0;

   bit exp_q[NREQ][$];

   sr_latch_ctrl #(.NREQ(NREQ), .NFLAG(NFLAG), .FW(FW), .PULSE_CYC(PULSE_CYC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .op    (op),
      .idx   (idx_v),
      .ack   (ack),
      .err   (err),
      .busy  (busy),
      .lat_e (lat_e),
      .lat_s (lat_s),
      .lat_r (lat_r),
      .q_fb  (q_fb)
   );

   always #5 clk = ~clk;

   // Gated SR latch bank; force_low models a stuck-at-0 readback path.
   always @(lat_e or lat_s or lat_r) begin
      if (lat_e) begin
         for (int f = 0; f < NFLAG; f++) begin
            if (lat_s[f])      q_lat[f] = 1'b1;
            else if (lat_r[f]) q_lat[f] = 1'b0;
         end
      end
   end
   assign q_fb = q_lat & ~force_low;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer plus per-cycle bank invariants.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("inv_s_and_r", 32'(lat_s & lat_r), 32'd0);
         check("inv_onehot_sr", 32'($onehot0(lat_s | lat_r)), 32'd1);
         check("inv_e_in_pulse", 32'(!lat_e || (dut.state_q == ST_PULSE)), 32'd1);
         if (ack != '0) begin
            check("ack_onehot", 32'($onehot(ack)), 32'd1);
            for (int k = 0; k < NREQ; k++) begin
               if (ack[k]) begin
                  check("ack_expected", 32'(exp_q[k].size() != 0), 32'd1);
                  if (exp_q[k].size() != 0) check("ack_err", 32'(err), 32'(exp_q[k].pop_front()));
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_txn(input int k, input logic o, input logic [FW-1:0] ix, input bit e_err);
      bit seen = 1'b0;
      op[k] = o;
      idx_v[k*FW +: FW] = ix;
      req[k] = 1'b1;
      exp_q[k].push_back(e_err);
      for (int c = 0; c < 40 && !seen; c++) begin
         tick();
         seen = ack[k];
      end
      check("txn_ack_seen", 32'(seen), 32'd1);
      req[k] = 1'b0;
      tick();
   endtask

   int          got_order[6];
   int          exp_order[6] = '{0, 1, 3, 0, 1, 3};
   int          n_ack;
   int          t_first, t_last;
   bit          pending[NREQ];
   int          pend_age[NREQ];
   int          max_wait;
   int          left;
   logic [FW-1:0] ix;

   initial begin
      rst_n = 1'b0;
      req   = '0;
      op    = '0;
      idx_v = '0;
      tick();
      tick();
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_lat_e", 32'(lat_e), 32'd0);
      check("rst_lat_s", 32'(lat_s), 32'd0);
      check("rst_lat_r", 32'(lat_r), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single set of flag 3 with full timing
      op[0] = 1'b1;
      idx_v[0 +: FW] = 3'd3;
      req = 4'b0001;
      exp_q[0].push_back(1'b0);
      tick();
      check("set_c1_lat_s", 32'(lat_s), 32'h08);
      check("set_c1_lat_r", 32'(lat_r), 32'h00);
      check("set_c1_lat_e", 32'(lat_e), 32'd0);
      check("set_c1_busy", 32'(busy), 32'd1);
      tick();
      check("set_c2_lat_e", 32'(lat_e), 32'd1);
      tick();
      check("set_c3_lat_e", 32'(lat_e), 32'd1);
      check("set_c3_lat_s", 32'(lat_s), 32'h08);
      tick();
      check("set_c4_lat_e", 32'(lat_e), 32'd0);
      check("set_c4_lat_s", 32'(lat_s), 32'h08);
      check("set_c4_ack", 32'(ack), 32'd0);
      tick();
      check("set_c5_ack", 32'(ack), 32'b0001);
      check("set_c5_lat_s", 32'(lat_s), 32'h00);
      check("set_q3", 32'(q_fb[3]), 32'd1);
      req = '0;
      tick();
      check("set_idle_busy", 32'(busy), 32'd0);

      // Bad index 7 answers in one cycle without touching the bank
      op[1] = 1'b1;
      idx_v[1*FW +: FW] = 3'd7;
      req = 4'b0010;
      exp_q[1].push_back(1'b1);
      tick();
      check("bad_c1_ack", 32'(ack), 32'b0010);
      check("bad_c1_err", 32'(err), 32'd1);
      check("bad_lat_e", 32'(lat_e), 32'd0);
      check("bad_lat_sr", 32'(lat_s | lat_r), 32'd0);
      req = '0;
      tick();

      do_txn(2, 1'b1, 3'd6, 1'b1);   // idx == NFLAG is out of range
      do_txn(2, 1'b1, 3'd5, 1'b0);   // last valid flag
      check("q5_set", 32'(q_fb[5]), 32'd1);
      do_txn(3, 1'b0, 3'd3, 1'b0);
      check("q3_reset", 32'(q_fb[3]), 32'd0);

      force_low = 6'b000100;
      do_txn(0, 1'b1, 3'd2, 1'b1);
      force_low = '0;

      // Reset in the middle of PULSE aborts without an ack
      op[2] = 1'b1;
      idx_v[2*FW +: FW] = 3'd1;
      req = 4'b0100;
      tick();
      tick();
      tick();
      check("abort_pre_lat_e", 32'(lat_e), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_lat_e", 32'(lat_e), 32'd0);
      check("abort_lat_s", 32'(lat_s), 32'd0);
      check("abort_ack", 32'(ack), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      op    = 4'b0011;
      idx_v = {3'd4, 3'd0, 3'd1, 3'd0};
      req   = 4'b1011;
      tick();
      for (int i = 0; i < 6; i++) exp_q[exp_order[i]].push_back(1'b0);
      rst_n = 1'b1;

      // Round-robin with requests held continuously
      n_ack = 0;
      t_first = 0;
      t_last = 0;
      for (int c = 0; c < 100 && n_ack < 6; c++) begin
         tick();
         if (ack != '0) begin
            for (int k = 0; k < NREQ; k++) if (ack[k]) got_order[n_ack] = k;
            if (n_ack == 0) t_first = c;
            t_last = c;
            n_ack++;
            if (n_ack == 6) req = '0;
         end
      end
      check("rr_ack_count", 32'(n_ack), 32'd6);
      for (int i = 0; i < 6; i++) check("rr_order", 32'(got_order[i]), 32'(exp_order[i]));
      check("rr_spacing", 32'(t_last - t_first), 32'(5 * (PULSE_CYC + 4)));
      tick();

      // Random soak; some requesters re-request by keeping req high after ack
      max_wait = 0;
      for (int k = 0; k < NREQ; k++) begin
         pending[k] = 1'b0;
         pend_age[k] = 0;
      end
      for (int cyc = 0; cyc < 10000; cyc++) begin
         tick();
         for (int k = 0; k < NREQ; k++) begin
            if (pending[k]) begin
               pend_age[k]++;
               if (ack[k]) begin
                  if (pend_age[k] > max_wait) max_wait = pend_age[k];
                  if (cyc < 9900 && $urandom_range(1, 0) == 1) begin
                     ix = FW'($urandom_range(7, 0));
                     op[k] = 1'($urandom_range(1, 0));
                     idx_v[k*FW +: FW] = ix;
                     exp_q[k].push_back(int'(ix) >= NFLAG);
                     pend_age[k] = 0;
                  end else begin
                     req[k] = 1'b0;
                     pending[k] = 1'b0;
                  end
               end
            end else if (cyc < 9900 && $urandom_range(3, 0) == 0) begin
               ix = FW'($urandom_range(7, 0));
               op[k] = 1'($urandom_range(1, 0));
               idx_v[k*FW +: FW] = ix;
               req[k] = 1'b1;
               pending[k] = 1'b1;
               pend_age[k] = 0;
               exp_q[k].push_back(int'(ix) >= NFLAG);
            end
         end
      end
      left = 0;
      for (int k = 0; k < NREQ; k++) left += int'(pending[k]) + exp_q[k].size();
      check("soak_drained", 32'(left), 32'd0);
      check("soak_no_starve", 32'(max_wait <= 4 * (PULSE_CYC + 4) + 8), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
